// File: rtl/wb_lsu_pkg.sv
// Shared types and lane helpers for the Wishbone load/store initiator.
// Size, error and state encodings plus byte-select and alignment rules.
package wb_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_BUS     = 2'b01,
        ERR_ALIGN   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic [3:0] lsu_sel(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return 4'b0011 << a;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Size 2'b11 has no legal encoding, so it is reported as misaligned.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            SZ_WORD: return |a;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/wb_lsu_lane.sv
// Byte-lane steering: write replication, lane selects, load shift and extension.
// Purely combinational (zero latency); no flow control.
module wb_lsu_lane
    import wb_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  a,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] dat,
    output logic [31:0] wdat,
    output logic [3:0]  sel,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = dat >> {a, 3'b000};
    assign sel     = lsu_sel(size, a);

    always_comb begin
        wdat  = wdata;
        rdata = shifted;
        case (size)
            SZ_BYTE: begin
                wdat  = {4{wdata[7:0]}};
                rdata = {{24{shifted[7] & ~uns}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wdat  = {2{wdata[15:0]}};
                rdata = {{16{shifted[15] & ~uns}}, shifted[15:0]};
            end
            SZ_WORD: ;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone pipelined initiator: one core load/store becomes one bus transfer.
// Latency 3 cycles accept->rsp with a zero-wait responder; single transfer in flight, ready only in IDLE.
module wb_lsu_master
    import wb_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state;
    logic        ready;
    logic        cyc;
    logic        stb;
    logic        rsp_vld;
    logic [31:0] rsp_dat;
    err_e        rsp_err;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic [15:0] cnt;

    logic [31:0] lane_wdat;
    logic [3:0]  lane_sel;
    logic [31:0] lane_rdata;
    logic        in_bus;
    logic        bus_done;
    logic        timed_out;

    wb_lsu_lane u_lane (
        .size  (lat_size),
        .a     (lat_addr[1:0]),
        .uns   (lat_uns),
        .wdata (lat_wdata),
        .dat   (wb_dat_i),
        .wdat  (lane_wdat),
        .sel   (lane_sel),
        .rdata (lane_rdata)
    );

    // A response in REQ only counts in the cycle the strobe is actually taken.
    assign in_bus    = (state == ST_REQ) || (state == ST_WAIT);
    assign bus_done  = ((state == ST_WAIT) || (state == ST_REQ && !wb_stall_i)) &&
                       (wb_ack_i || wb_err_i);
    assign timed_out = in_bus && (cnt == TO_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= ST_IDLE;
            ready     <= 1'b1;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            rsp_vld   <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= ERR_OK;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        lat_we    <= req_we_i;
                        lat_addr  <= req_addr_i;
                        lat_wdata <= req_wdata_i;
                        lat_size  <= req_size_i;
                        lat_uns   <= req_unsigned_i;
                        ready     <= 1'b0;
                        if (lsu_misaligned(req_size_i, req_addr_i[1:0])) begin
                            state   <= ST_RESP;
                            rsp_vld <= 1'b1;
                            rsp_err <= ERR_ALIGN;
                            rsp_dat <= '0;
                        end else begin
                            state <= ST_REQ;
                            cyc   <= 1'b1;
                            stb   <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (bus_done) begin
                        state   <= ST_RESP;
                        cyc     <= 1'b0;
                        stb     <= 1'b0;
                        rsp_vld <= 1'b1;
                        rsp_err <= wb_err_i ? ERR_BUS : ERR_OK;
                        rsp_dat <= (wb_err_i || lat_we) ? 32'd0 : lane_rdata;
                    end else if (timed_out) begin
                        state   <= ST_RESP;
                        cyc     <= 1'b0;
                        stb     <= 1'b0;
                        rsp_vld <= 1'b1;
                        rsp_err <= ERR_TIMEOUT;
                        rsp_dat <= '0;
                    end else if (state == ST_REQ && !wb_stall_i) begin
                        state <= ST_WAIT;
                        stb   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state   <= ST_IDLE;
                        ready   <= 1'b1;
                        rsp_vld <= 1'b0;
                        rsp_dat <= '0;
                        rsp_err <= ERR_OK;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = ready;
    assign rsp_valid_o = rsp_vld;
    assign rsp_rdata_o = rsp_dat;
    assign rsp_err_o   = rsp_err;
    assign wb_cyc_o    = cyc;
    assign wb_stb_o    = stb;
    // Bus payload is forced to zero outside a cycle so idle outputs read as 0.
    assign wb_we_o     = cyc & lat_we;
    assign wb_adr_o    = cyc ? {lat_addr[31:2], 2'b00} : 32'd0;
    assign wb_dat_o    = cyc ? lane_wdat : 32'd0;
    assign wb_sel_o    = cyc ? lane_sel : 4'd0;

endmodule
